// File: rtl/prim_clock_gate_ctrl.sv
// Idle-driven enable controller for a downstream prim_clock_gating cell.
// Optional gating-event counter (gate_cnt_o) enabled by PRIM_CLK_GATE_CTRL_STATS_EN.
module prim_clock_gate_ctrl #(
  parameter int IdleThreshold = 16,
  parameter int WakeCycles    = 2
`ifdef PRIM_CLK_GATE_CTRL_STATS_EN
  ,
  parameter int CntW          = 16
`endif
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            idle_i,
  input  logic            wake_req_i,
  input  logic            sw_force_en_i,
  output logic            en_o,
  output logic            gated_o,
  output logic            wake_ack_o
`ifdef PRIM_CLK_GATE_CTRL_STATS_EN
  ,
  output logic [CntW-1:0] gate_cnt_o
`endif
);

  localparam int IdleW = $clog2(IdleThreshold + 1);
  localparam int WakeW = $clog2(WakeCycles + 1);
  localparam logic [IdleW-1:0] IdleLast = IdleW'(IdleThreshold - 1);
  localparam logic [WakeW-1:0] WakeLast = WakeW'(WakeCycles - 1);

  typedef enum logic [1:0] {
    RUN,
    GATED,
    WAKE
  } state_e;

  state_e            state, state_d;
  logic [IdleW-1:0]  idle_cnt, idle_cnt_d;
  logic [WakeW-1:0]  wake_cnt, wake_cnt_d;
  logic              req_served, req_served_d;
  logic              ack_d;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state      <= RUN;
      idle_cnt   <= '0;
      wake_cnt   <= '0;
      req_served <= 1'b0;
      en_o       <= 1'b1;
      gated_o    <= 1'b0;
      wake_ack_o <= 1'b0;
    end else begin
      state      <= state_d;
      idle_cnt   <= idle_cnt_d;
      wake_cnt   <= wake_cnt_d;
      req_served <= req_served_d;
      en_o       <= (state_d != GATED);
      gated_o    <= (state_d == GATED);
      wake_ack_o <= ack_d;
    end
  end

  always_comb begin
    state_d      = state;
    idle_cnt_d   = idle_cnt;
    wake_cnt_d   = wake_cnt;
    req_served_d = req_served;
    ack_d        = 1'b0;
    unique case (state)
      RUN: begin
        // A pending wake request or software force both block idle accumulation.
        if (idle_i && !sw_force_en_i && !wake_req_i) begin
          if (idle_cnt == IdleLast) begin
            state_d    = GATED;
            idle_cnt_d = '0;
          end else begin
            idle_cnt_d = idle_cnt + IdleW'(1);
          end
        end else begin
          idle_cnt_d = '0;
        end
        if (wake_req_i && !req_served) begin
          ack_d        = 1'b1;
          req_served_d = 1'b1;
        end
      end
      GATED: begin
        if (wake_req_i || !idle_i || sw_force_en_i) begin
          state_d    = WAKE;
          wake_cnt_d = '0;
        end
      end
      WAKE: begin
        if (wake_cnt == WakeLast) begin
          state_d    = RUN;
          wake_cnt_d = '0;
          if (wake_req_i && !req_served) begin
            ack_d        = 1'b1;
            req_served_d = 1'b1;
          end
        end else begin
          wake_cnt_d = wake_cnt + WakeW'(1);
        end
      end
      default: state_d = RUN;
    endcase
    if (!wake_req_i) req_served_d = 1'b0;
  end

`ifdef PRIM_CLK_GATE_CTRL_STATS_EN
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      gate_cnt_o <= '0;
    end else if (state == RUN && state_d == GATED && gate_cnt_o != '1) begin
      gate_cnt_o <= gate_cnt_o + CntW'(1);
    end
  end
`endif

endmodule
